// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory load/store unit.
// Size codes follow RISC-V funct3 for loads and stores.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wdata);
    case (sz)
      2'b00:   store_lanes = {4{wdata[7:0]}};
      2'b01:   store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
      SZ_BU:   load_extend = {24'b0, sh[7:0]};
      SZ_HU:   load_extend = {16'b0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Four independent 8-bit lanes sharing one address; synchronous read,
// per-lane write enable. Read data holds while en is low.
module dmem_bytelane_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-3:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 2**(ADDR_W-2);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[i]) mem[addr] <= wdata[8*i +: 8];
        rd_q <= mem[addr];
      end
    end

    assign rdata[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-lane RAM: one request in flight,
// byte/half stores via lane enables, extended loads, error screening at accept.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_busy
);
  localparam int WA = ADDR_W - 2;

  state_e          state_q, state_d;
  logic [WA-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      off_q, off_d;
  logic            err_q, err_d;

  logic            accept, req_err, oor, misal, illegal, init_wr;
  logic            ram_en;
  logic [3:0]      ram_we;
  logic [WA-1:0]   ram_addr;
  logic [31:0]     ram_wdata, ram_rdata;

  // Gating with rst_n keeps req_ready low while reset is held, even when
  // the unit comes out of reset straight into IDLE.
  assign req_ready  = rst_n && (state_q == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign init_busy  = (state_q == ST_INIT);
  assign resp_valid = (state_q == ST_RESP);

  assign oor     = (req_addr >> ADDR_W) != 32'd0;
  assign misal   = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign illegal = (req_size == 3'b011) || (req_size == 3'b110) || (req_size == 3'b111) ||
                   (req_we && req_size[2]);
  assign req_err = oor || misal || illegal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    off_d   = off_q;
    err_d   = err_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESP;
          we_d    = req_we;
          size_d  = req_size;
          off_d   = req_addr[1:0];
          err_d   = req_err;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end

  // The RAM is only enabled on a clear step or an accept, so its read
  // register freezes for the whole RESP stall.
  assign init_wr   = rst_n && (state_q == ST_INIT);
  assign ram_en    = init_wr || accept;
  assign ram_addr  = init_wr ? cnt_q : req_addr[ADDR_W-1:2];
  assign ram_we    = init_wr ? 4'hF :
                     (accept && req_we && !req_err) ? store_be(req_size[1:0], req_addr[1:0]) : 4'h0;
  assign ram_wdata = init_wr ? 32'd0 : store_lanes(req_size[1:0], req_wdata);

  dmem_bytelane_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_extend(size_q, off_q, ram_rdata) : 32'd0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench: small clearing instance (ADDR_W=6) for function checks,
// plus a full-width no-clear instance for immediate-ready and range checks.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, init_busy;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_size;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err, b_init_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [2:0]  b_req_size;

  int tests = 0;
  int fails = 0;
  logic b_rdy1;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .init_busy(init_busy)
  );

  dmem_lsu #(.ADDR_W(14), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_size(b_req_size), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .init_busy(b_init_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 right after rst_n rises; returns at the negedge of the first ready cycle.
  task automatic wait_init(output int busy, output int first);
    busy = 0;
    first = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      @(negedge clk);
      if (init_busy) busy++;
      if (req_ready) first = c;
      if (c == 1) b_rdy1 = b_req_ready;
    end
  endtask

  // Called at a negedge with resp_ready high; returns at the negedge after the response is taken.
  task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("resp_latency", {31'b0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic e;
    access(1'b0, addr, size, 32'd0, d, e);
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  task automatic st(input string tag, input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] wdata, input logic exp_err);
    logic [31:0] d;
    logic e;
    access(1'b1, addr, size, wdata, d, e);
    chk({tag, "_data"}, d, 32'd0);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, first;
    rst_n = 1'b0; resp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = SZ_W; req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_size = SZ_W; b_req_wdata = '0;
    b_resp_ready = 1'b1;
    b_rdy1 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_init_busy", {31'b0, init_busy}, 32'd1);
    chk("rst_b_req_ready", {31'b0, b_req_ready}, 32'd0);
    chk("rst_b_init_busy", {31'b0, b_init_busy}, 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init(busy, first);
    chk("init_busy_cycles", busy, 32'd16);
    chk("init_first_ready", first, 32'd17);
    chk("b_ready_first_cycle", {31'b0, b_rdy1}, 32'd1);

    ld("lw_3c_cleared", 32'h3C, SZ_W, 32'h0, 1'b0);
    st("sw_10", 32'h10, SZ_W, 32'h11223344, 1'b0);
    st("sb_11", 32'h11, SZ_B, 32'hFFFF_FFAB, 1'b0);
    ld("lw_10", 32'h10, SZ_W, 32'h1122AB44, 1'b0);
    ld("lb_11", 32'h11, SZ_B, 32'hFFFFFFAB, 1'b0);
    ld("lbu_11", 32'h11, SZ_BU, 32'h000000AB, 1'b0);
    ld("lb_10_pos", 32'h10, SZ_B, 32'h00000044, 1'b0);
    ld("lbu_13", 32'h13, SZ_BU, 32'h00000011, 1'b0);
    ld("lh_10", 32'h10, SZ_H, 32'hFFFFAB44, 1'b0);

    st("sw_20", 32'h20, SZ_W, 32'h0000BEEF, 1'b0);
    st("sh_22", 32'h22, SZ_H, 32'h00008001, 1'b0);
    ld("lh_22", 32'h22, SZ_H, 32'hFFFF8001, 1'b0);
    ld("lhu_22", 32'h22, SZ_HU, 32'h00008001, 1'b0);
    ld("lw_20", 32'h20, SZ_W, 32'h8001BEEF, 1'b0);

    ld("lh_13_misal", 32'h13, SZ_H, 32'h0, 1'b1);
    st("sw_12_misal", 32'h12, SZ_W, 32'hDEADBEEF, 1'b1);
    ld("lw_10_after_misal", 32'h10, SZ_W, 32'h1122AB44, 1'b0);
    ld("size011", 32'h10, 3'b011, 32'h0, 1'b1);
    st("store_sz100", 32'h10, SZ_BU, 32'h0, 1'b1);
    ld("lw_10_after_illegal", 32'h10, SZ_W, 32'h1122AB44, 1'b0);
    st("sb_40_oor", 32'h40, SZ_B, 32'hFF, 1'b1);
    ld("lw_00_after_oor", 32'h00, SZ_W, 32'h0, 1'b0);

    // Wide instance: boundary of the 14-bit byte space
    b_req_valid = 1'b1; b_req_addr = 32'h00004000; b_req_size = SZ_W;
    chk("b_ready", {31'b0, b_req_ready}, 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("b_oor_valid", {31'b0, b_resp_valid}, 32'd1);
    chk("b_oor_err", {31'b0, b_resp_err}, 32'd1);
    chk("b_oor_rdata", b_resp_rdata, 32'd0);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = 32'h00003FFC;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("b_inrange_err", {31'b0, b_resp_err}, 32'd0);
    @(negedge clk);

    // Back-pressure: response held while a competing request waits
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = SZ_W;
    @(posedge clk); #1;
    req_addr = 32'h20; req_size = SZ_B;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, 32'h1122AB44);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("resume_req_ready", {31'b0, req_ready}, 32'd1);
    chk("resume_resp_valid", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b0;

    // Reset while a response is pending
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h10; req_size = SZ_W;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_resp_drop", {31'b0, resp_valid}, 32'd0);
    chk("rst_reinit_busy", {31'b0, init_busy}, 32'd1);
    chk("rst_reinit_ready", {31'b0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init(busy, first);
    chk("reinit_busy_cycles", busy, 32'd16);
    chk("reinit_first_ready", first, 32'd17);
    ld("lw_10_cleared", 32'h10, SZ_W, 32'h0, 1'b0);
    ld("lw_20_cleared", 32'h20, SZ_W, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
